// File: rtl/cic_pkg.sv
// Shared limits and width helpers for the CIC decimator.
package cic_pkg;

  localparam int MIN_ORDER = 1;
  localparam int MAX_ORDER = 6;
  localparam int MIN_DECIM = 2;
  localparam int MAX_DECIM = 1024;
  localparam int MIN_OUT_W = 2;

  // Bit growth of an N-stage CIC is N*log2(R); two extra bits carry the +/-1 input.
  function automatic int cic_acc_w(input int order, input int decim);
    return order * $clog2(decim) + 2;
  endfunction

  function automatic bit cic_is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/cic_integrator.sv
// One enabled, wrapping accumulator stage of the CIC integrator chain.
module cic_integrator
  import cic_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_en,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_acc
);

  logic [W-1:0] r_acc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + i_din;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/cic_decimator.sv
// CIC decimator for a 1-bit sigma-delta stream: ORDER integrators, decimate by DECIM, ORDER combs.
// Define CIC_ROUND_EN for round-half-up with positive saturation; otherwise the output is floor-truncated.
module cic_decimator
  import cic_pkg::*;
#(
  parameter int ORDER = 3,
  parameter int DECIM = 64,
  parameter int OUT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic                    in_bit,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] out_data
);

  localparam int ACC_W = cic_acc_w(ORDER, DECIM);
  localparam int CNT_W = $clog2(DECIM);
  localparam int SHIFT = ACC_W - OUT_W;
  localparam logic [CNT_W-1:0] LAST_PHASE = CNT_W'(DECIM - 1);

  generate
    if (ORDER < MIN_ORDER || ORDER > MAX_ORDER ||
        DECIM < MIN_DECIM || DECIM > MAX_DECIM || !cic_is_pow2(DECIM) ||
        OUT_W < MIN_OUT_W || OUT_W > ACC_W) begin : g_bad_param
      $error("cic_decimator: illegal ORDER/DECIM/OUT_W combination");
    end
  endgenerate

  logic [ACC_W-1:0]        w_int  [0:ORDER];
  logic [ACC_W-1:0]        w_comb [0:ORDER];
  logic [CNT_W-1:0]        r_phase;
  logic                    r_tick;
  logic signed [ACC_W-1:0] r_comb;
  logic                    r_comb_vld;
  logic signed [OUT_W-1:0] w_scaled;

  assign w_int[0] = in_bit ? {{(ACC_W-1){1'b0}}, 1'b1} : {ACC_W{1'b1}};

  for (genvar k = 0; k < ORDER; k++) begin : g_int
    cic_integrator #(.W(ACC_W)) u_int (
      .clk   (clk),
      .reset (reset),
      .i_en  (in_valid),
      .i_din (w_int[k]),
      .o_acc (w_int[k+1])
    );
  end

  // The tick is a one-shot: once raised it always drains through the comb/output stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_phase <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_tick <= in_valid && (r_phase == LAST_PHASE);
      if (in_valid) begin
        r_phase <= r_phase + 1'b1;
      end
    end
  end

  assign w_comb[0] = w_int[ORDER];

  for (genvar k = 0; k < ORDER; k++) begin : g_comb
    logic [ACC_W-1:0] r_dly;

    always_ff @(posedge clk) begin
      if (reset) begin
        r_dly <= '0;
      end else if (r_tick) begin
        r_dly <= w_comb[k];
      end
    end

    assign w_comb[k+1] = w_comb[k] - r_dly;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_comb     <= '0;
      r_comb_vld <= 1'b0;
    end else begin
      r_comb_vld <= r_tick;
      if (r_tick) begin
        r_comb <= $signed(w_comb[ORDER]);
      end
    end
  end

`ifdef CIC_ROUND_EN
  generate
    if (SHIFT == 0) begin : g_pass
      assign w_scaled = r_comb;
    end else begin : g_round
      localparam logic signed [ACC_W:0] HALF = {{ACC_W{1'b0}}, 1'b1} << (SHIFT - 1);
      localparam logic signed [OUT_W-1:0] MAX_POS = {1'b0, {(OUT_W-1){1'b1}}};
      logic signed [ACC_W:0] w_sum;
      logic signed [OUT_W:0] w_rnd;

      // One guard bit absorbs the rounding carry; only positive overflow is possible.
      assign w_sum    = (ACC_W+1)'(r_comb) + HALF;
      assign w_rnd    = (OUT_W+1)'(w_sum >>> SHIFT);
      assign w_scaled = (w_rnd[OUT_W] != w_rnd[OUT_W-1]) ? MAX_POS : w_rnd[OUT_W-1:0];
    end
  endgenerate
`else
  assign w_scaled = OUT_W'(r_comb >>> SHIFT);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= r_comb_vld;
      if (r_comb_vld) begin
        out_data <= w_scaled;
      end
    end
  end

endmodule
